// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests
// and buffers responses for decode, dropping wrong-path data after redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  input  logic        if_ready_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [AW:0]   outstanding;
  logic [AW:0]   out_next;
  logic [AW:0]   fifo_count;
  logic [AW:0]   credit_used;
  logic [AW-1:0] tag_wptr;
  logic [AW-1:0] tag_rptr;
  logic [AW-1:0] fifo_wptr;
  logic [AW-1:0] fifo_rptr;
  logic [31:0]   tag_q      [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic          xfer;
  logic          rsp;
  logic          push;
  logic          pop;

  assign if_valid_o = (fifo_count != '0) & !redirect_i;
  assign if_instr_o = fifo_instr[fifo_rptr];
  assign if_pc_o    = fifo_pc[fifo_rptr];
  assign pop        = if_valid_o & if_ready_i;

  // A slot popped this cycle is free before any new response can land,
  // which is what lets a 1-cycle memory stream at one word per cycle.
  assign credit_used = fifo_count - (AW+1)'(pop) + outstanding;

  assign imem_req_o  = (state == RUN) & !redirect_i & (credit_used < DEPTH);
  assign imem_addr_o = pc;
  assign xfer        = imem_req_o & imem_gnt_i;

  assign rsp  = imem_rvalid_i & (outstanding != '0);
  assign push = rsp & (state == RUN) & !redirect_i;

  assign out_next = outstanding + (AW+1)'(xfer) - (AW+1)'(rsp);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      outstanding <= '0;
      tag_wptr    <= '0;
      tag_rptr    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      outstanding <= out_next;
      if (xfer) begin
        tag_q[tag_wptr] <= pc;
        tag_wptr        <= tag_wptr + AW'(1);
      end
      if (rsp) begin
        tag_rptr <= tag_rptr + AW'(1);
      end
      if (redirect_i) begin
        pc <= redirect_pc_i & ~32'h3;
      end else if (xfer) begin
        pc <= pc + 32'd4;
      end
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect_i && out_next != '0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_next == '0) begin
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_count <= '0;
      fifo_wptr  <= '0;
      fifo_rptr  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (redirect_i) begin
      fifo_count <= '0;
      fifo_wptr  <= '0;
      fifo_rptr  <= '0;
    end else begin
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) begin
        fifo_pc[fifo_wptr]    <= tag_q[tag_rptr];
        fifo_instr[fifo_wptr] <= imem_rdata_i;
        fifo_wptr             <= fifo_wptr + AW'(1);
      end
      if (pop) begin
        fifo_rptr <= fifo_rptr + AW'(1);
      end
    end
  end

  rvalid_expected: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> outstanding != '0
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with configurable
// latency, scenario tasks with inline expected-value checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        if_ready_i = 1'b1;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_ready_i    (if_ready_i)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .imem_req_o    (w_req),
    .imem_addr_o   (w_addr),
    .imem_gnt_i    (1'b1),
    .imem_rvalid_i (1'b0),
    .imem_rdata_i  (32'h0),
    .if_valid_o    (w_valid),
    .if_instr_o    (w_instr),
    .if_pc_o       (w_pc),
    .if_ready_i    (1'b1)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  pend_t       pend[$];
  logic [31:0] req_log[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_instr[$];
  int          dlv_cyc[$];
  logic [31:0] w_addrs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic prep();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
    #1;
  endtask

  task automatic commit();
    if (imem_req_o && imem_gnt_i) begin
      req_log.push_back(imem_addr_o);
      pend.push_back('{addr: imem_addr_o, due: cyc + lat});
    end
    if (if_valid_o && if_ready_i) begin
      dlv_pc.push_back(if_pc_o);
      dlv_instr.push_back(if_instr_o);
      dlv_cyc.push_back(cyc);
    end
    if (rst_ni && w_req) begin
      w_addrs.push_back(w_addr);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick();
    prep();
    commit();
  endtask

  task automatic clear_logs();
    req_log.delete();
    dlv_pc.delete();
    dlv_instr.delete();
    dlv_cyc.delete();
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    if_ready_i    = 1'b1;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    lat           = 1;
    pend.delete();
    w_addrs.delete();
    clear_logs();
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    cyc    = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: req=%b valid=%b want 0 0",
               imem_req_o, if_valid_o);
    end
    checks++;
    if (imem_addr_o !== 32'h0 || if_instr_o !== 32'h0 ||
        if_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h instr=%h pc=%h want 0 0 0",
               imem_addr_o, if_instr_o, if_pc_o);
    end
    checks++;
    if (w_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL reset_pc_param: addr=%h want fffffffc", w_addr);
    end
    // run a little, then assert reset asynchronously mid-operation
    do_reset();
    repeat (4) tick();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0 ||
        imem_addr_o !== 32'h0 || if_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: req=%b valid=%b addr=%h pc=%h want 0",
               imem_req_o, if_valid_o, imem_addr_o, if_pc_o);
    end
  endtask

  task automatic test_boot();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    do_reset();
    prep();
    checks++;
    if (imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_req: req=%b want 0", imem_req_o);
    end
    commit();
    prep();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL boot_first_req: req=%b addr=%h want 1 0",
               imem_req_o, imem_addr_o);
    end
    commit();
    repeat (6) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= dlv_pc.size() || dlv_pc[i] !== exp_pc[i] ||
          dlv_instr[i] !== instr_of(exp_pc[i]) || dlv_cyc[i] != 3 + i) begin
        errors++;
        $display("FAIL boot_stream[%0d]: pc=%h cyc=%0d want %h cyc %0d",
                 i, dlv_pc[i], dlv_cyc[i], exp_pc[i], 3 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    do_reset();
    if_ready_i = 1'b0;
    repeat (8) tick();
    checks++;
    if (req_log.size() != 2 || req_log[0] !== 32'h0 ||
        req_log[1] !== 32'h4) begin
      errors++;
      $display("FAIL bp_req_count: n=%0d first=%h second=%h want 2 0 4",
               req_log.size(), req_log[0], req_log[1]);
    end
    prep();
    checks++;
    if (imem_req_o !== 1'b0 || if_valid_o !== 1'b1 ||
        if_pc_o !== 32'h0 || if_instr_o !== instr_of(32'h0)) begin
      errors++;
      $display("FAIL bp_hold: req=%b valid=%b pc=%h want 0 1 0",
               imem_req_o, if_valid_o, if_pc_o);
    end
    commit();
    if_ready_i = 1'b1;
    prep();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
      errors++;
      $display("FAIL bp_resume: req=%b addr=%h want 1 8",
               imem_req_o, imem_addr_o);
    end
    commit();
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= dlv_pc.size() || dlv_pc[i] !== exp_pc[i] ||
          dlv_cyc[i] != dlv_cyc[0] + i) begin
        errors++;
        $display("FAIL bp_drain[%0d]: pc=%h want %h", i, dlv_pc[i],
                 exp_pc[i]);
      end
    end
  endtask

  task automatic test_redirect_idle();
    int bad;
    do_reset();
    if_ready_i = 1'b0;
    repeat (6) tick();
    if_ready_i = 1'b1;
    tick();
    if_ready_i = 1'b0;
    repeat (3) tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    if_ready_i    = 1'b1;
    prep();
    checks++;
    if (if_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rdi_cycle: valid=%b req=%b want 0 0",
               if_valid_o, imem_req_o);
    end
    commit();
    redirect_i = 1'b0;
    prep();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0100 ||
        if_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rdi_next: req=%b addr=%h valid=%b want 1 100 0",
               imem_req_o, imem_addr_o, if_valid_o);
    end
    commit();
    repeat (6) tick();
    checks++;
    if (dlv_pc.size() < 2 || dlv_pc[1] !== 32'h0000_0100 ||
        dlv_instr[1] !== instr_of(32'h0000_0100)) begin
      errors++;
      $display("FAIL rdi_first: pc=%h want 00000100", dlv_pc[1]);
    end
    bad = 0;
    foreach (dlv_pc[i]) begin
      if (dlv_pc[i] == 32'h4 || dlv_pc[i] == 32'h8) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rdi_stale: stale deliveries=%0d want 0", bad);
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    lat = 3;
    repeat (3) tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    prep();
    checks++;
    if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rdd_cycle: req=%b valid=%b want 0 0",
               imem_req_o, if_valid_o);
    end
    commit();
    redirect_i = 1'b0;
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      prep();
      checks++;
      if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0000_0200) begin
        errors++;
        $display("FAIL rdd_drain[%0d]: req=%b addr=%h want 0 200",
                 i, imem_req_o, imem_addr_o);
      end
      commit();
    end
    prep();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0200) begin
      errors++;
      $display("FAIL rdd_resume: req=%b addr=%h want 1 200",
               imem_req_o, imem_addr_o);
    end
    commit();
    repeat (8) tick();
    checks++;
    if (dlv_pc.size() == 0 || dlv_pc[0] !== 32'h0000_0200 ||
        dlv_instr[0] !== instr_of(32'h0000_0200)) begin
      errors++;
      $display("FAIL rdd_first: pc=%h want 00000200", dlv_pc[0]);
    end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    lat = 3;
    tick();
    prep();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL rdc_req0: req=%b addr=%h want 1 0",
               imem_req_o, imem_addr_o);
    end
    commit();
    imem_gnt_i = 1'b0;
    tick();
    imem_gnt_i = 1'b1;
    prep();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      errors++;
      $display("FAIL rdc_nognt: req=%b addr=%h want 1 4",
               imem_req_o, imem_addr_o);
    end
    commit();
    // first redirect lands in the same cycle as the response for 0x0
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0280;
    prep();
    checks++;
    if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rdc_cycle: req=%b valid=%b want 0 0",
               imem_req_o, if_valid_o);
    end
    commit();
    clear_logs();
    redirect_pc_i = 32'h0000_0300;
    prep();
    checks++;
    if (imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rdc_second: req=%b want 0", imem_req_o);
    end
    commit();
    redirect_i = 1'b0;
    prep();
    checks++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0000_0300) begin
      errors++;
      $display("FAIL rdc_drain: req=%b addr=%h want 0 300",
               imem_req_o, imem_addr_o);
    end
    commit();
    prep();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0300) begin
      errors++;
      $display("FAIL rdc_resume: req=%b addr=%h want 1 300",
               imem_req_o, imem_addr_o);
    end
    commit();
    repeat (8) tick();
    checks++;
    if (req_log.size() == 0 || req_log[0] !== 32'h0000_0300) begin
      errors++;
      $display("FAIL rdc_reqlog: first=%h want 00000300", req_log[0]);
    end
    checks++;
    if (dlv_pc.size() == 0 || dlv_pc[0] !== 32'h0000_0300 ||
        dlv_instr[0] !== instr_of(32'h0000_0300)) begin
      errors++;
      $display("FAIL rdc_first: pc=%h want 00000300", dlv_pc[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (5) tick();
    checks++;
    if (w_addrs.size() != 2 || w_addrs[0] !== 32'hFFFF_FFFC ||
        w_addrs[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap: n=%0d a0=%h a1=%h want 2 fffffffc 0",
               w_addrs.size(), w_addrs[0], w_addrs[1]);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect_idle();
    test_redirect_drain();
    test_redirect_coincident();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
